// File: rtl/edge_counter_param.sv
// edge_counter_param: parametrised edge-qualified up/down event counter with load, wrap/saturate and sticky limit flags
module edge_counter_param #(
  parameter int WIDTH = 8,
  parameter bit SAT = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_num_i,
  input  logic             i_en,
  input  logic             i_dir,
  input  logic [1:0]       i_edge_sel,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_of_clr,
  output logic             o_of,
  output logic             o_uf,
  output logic             o_tc,
  output logic [WIDTH-1:0] c_cnt
);
  localparam logic [WIDTH-1:0] MAX = '1;
  logic num_q;
  logic evt;
  logic step;
  logic hit_of;
  logic hit_uf;
  logic [WIDTH-1:0] cnt_nxt;
  // qualify the event and work out the next count and limit hits
  always_comb begin
    evt = i_edge_sel == 2'b00 ? i_num_i :
          i_edge_sel == 2'b01 ? i_num_i & ~num_q :
          i_edge_sel == 2'b10 ? ~i_num_i & num_q :
                                i_num_i ^ num_q;
    step = i_en & ~i_load & evt;
    hit_of = step & i_dir & (c_cnt == MAX);
    hit_uf = step & ~i_dir & (c_cnt == '0);
    cnt_nxt = i_load ? i_load_val :
              !step ? c_cnt :
              (SAT && (hit_of || hit_uf)) ? c_cnt :
              i_dir ? c_cnt + WIDTH'(1) : c_cnt - WIDTH'(1);
  end
  // state update; the input history is reloaded on reset so release never fabricates an edge
  always_ff @(posedge i_clk) begin
    num_q <= i_num_i;
    if (!i_rst_n) begin
      c_cnt <= '0;
      o_of <= 1'b0;
      o_uf <= 1'b0;
      o_tc <= 1'b0;
    end else begin
      c_cnt <= cnt_nxt;
      o_tc <= hit_of | hit_uf;
      o_of <= (o_of & ~i_of_clr) | hit_of;
      o_uf <= (o_uf & ~i_of_clr) | hit_uf;
    end
  end
endmodule

// File: tb/tb_edge_counter_param.sv
// tb_edge_counter_param: directed checks of an 8-bit wrapping and a 4-bit saturating counter
module tb_edge_counter_param;
  logic clk = 1'b0;
  logic rst_n, num, en, dir, load, of_clr;
  logic [1:0] sel;
  logic [7:0] lv8;
  logic [3:0] lv4;
  logic of8, uf8, tc8, of4, uf4, tc4;
  logic [7:0] cnt8;
  logic [3:0] cnt4;
  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  edge_counter_param #(.WIDTH(8), .SAT(1'b0)) d8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_num_i(num), .i_en(en), .i_dir(dir),
    .i_edge_sel(sel), .i_load(load), .i_load_val(lv8), .i_of_clr(of_clr),
    .o_of(of8), .o_uf(uf8), .o_tc(tc8), .c_cnt(cnt8)
  );

  edge_counter_param #(.WIDTH(4), .SAT(1'b1)) d4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_num_i(num), .i_en(en), .i_dir(dir),
    .i_edge_sel(sel), .i_load(load), .i_load_val(lv4), .i_of_clr(of_clr),
    .o_of(of4), .o_uf(uf4), .o_tc(tc4), .c_cnt(cnt4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic n);
    rst_n = 1'b0; num = n; en = 1'b0; dir = 1'b1; sel = 2'b00;
    load = 1'b0; of_clr = 1'b0; lv8 = '0; lv4 = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    n_run++; if (cnt8 !== 8'h00) begin n_fail++; $display("FAIL reset_cnt8 got=%h exp=00", cnt8); end
    n_run++; if ({of8, uf8, tc8} !== 3'b000) begin n_fail++; $display("FAIL reset_flags8 got=%b exp=000", {of8, uf8, tc8}); end
    n_run++; if (cnt4 !== 4'h0) begin n_fail++; $display("FAIL reset_cnt4 got=%h exp=0", cnt4); end
    n_run++; if ({of4, uf4, tc4} !== 3'b000) begin n_fail++; $display("FAIL reset_flags4 got=%b exp=000", {of4, uf4, tc4}); end
  endtask

  task automatic test_level();
    do_reset(1'b0);
    num = 1'b1; en = 1'b1; dir = 1'b1; sel = 2'b00;
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_run++; if (cnt8 !== 8'(i)) begin n_fail++; $display("FAIL level_cnt step%0d got=%h exp=%h", i, cnt8, 8'(i)); end
    end
    n_run++; if (of8 !== 1'b0) begin n_fail++; $display("FAIL level_of got=%b exp=0", of8); end
  endtask

  task automatic test_edges();
    do_reset(1'b0);
    en = 1'b1; sel = 2'b01;
    for (int i = 0; i < 20; i++) begin num = ~num; tick(); end
    n_run++; if (cnt8 !== 8'd10) begin n_fail++; $display("FAIL rising_cnt got=%0d exp=10", cnt8); end
    do_reset(1'b0);
    en = 1'b1; sel = 2'b11;
    for (int i = 0; i < 20; i++) begin num = ~num; tick(); end
    n_run++; if (cnt8 !== 8'd20) begin n_fail++; $display("FAIL both_cnt got=%0d exp=20", cnt8); end
    do_reset(1'b0);
    en = 1'b1; sel = 2'b10;
    for (int i = 0; i < 20; i++) begin num = ~num; tick(); end
    n_run++; if (cnt8 !== 8'd10) begin n_fail++; $display("FAIL falling_cnt got=%0d exp=10", cnt8); end
    do_reset(1'b1);
    en = 1'b1; sel = 2'b01; num = 1'b1;
    tick();
    n_run++; if (cnt8 !== 8'd0) begin n_fail++; $display("FAIL release_high_rising got=%0d exp=0", cnt8); end
    sel = 2'b11;
    tick();
    n_run++; if (cnt8 !== 8'd0) begin n_fail++; $display("FAIL release_high_both got=%0d exp=0", cnt8); end
  endtask

  task automatic test_wrap();
    do_reset(1'b0);
    load = 1'b1; lv8 = 8'hFE;
    tick();
    n_run++; if (cnt8 !== 8'hFE || tc8 !== 1'b0) begin n_fail++; $display("FAIL wrap_load got=%h tc=%b exp=fe tc=0", cnt8, tc8); end
    load = 1'b0; en = 1'b1; dir = 1'b1; sel = 2'b00; num = 1'b1;
    tick();
    n_run++; if ({cnt8, tc8, of8} !== {8'hFF, 2'b00}) begin n_fail++; $display("FAIL wrap_ff got=%h tc=%b of=%b exp=ff 0 0", cnt8, tc8, of8); end
    tick();
    n_run++; if ({cnt8, tc8, of8} !== {8'h00, 2'b11}) begin n_fail++; $display("FAIL wrap_00 got=%h tc=%b of=%b exp=00 1 1", cnt8, tc8, of8); end
    tick();
    n_run++; if ({cnt8, tc8, of8} !== {8'h01, 2'b01}) begin n_fail++; $display("FAIL wrap_01 got=%h tc=%b of=%b exp=01 0 1", cnt8, tc8, of8); end
    en = 1'b0; of_clr = 1'b1;
    tick();
    of_clr = 1'b0;
    n_run++; if ({cnt8, of8} !== {8'h01, 1'b0}) begin n_fail++; $display("FAIL of_clear got=%h of=%b exp=01 0", cnt8, of8); end
    load = 1'b1; lv8 = 8'hFF;
    tick();
    load = 1'b0; en = 1'b1; of_clr = 1'b1;
    tick();
    of_clr = 1'b0;
    n_run++; if ({cnt8, tc8, of8} !== {8'h00, 2'b11}) begin n_fail++; $display("FAIL clr_vs_wrap got=%h tc=%b of=%b exp=00 1 1", cnt8, tc8, of8); end
    load = 1'b1; lv8 = 8'h00;
    tick();
    load = 1'b0; dir = 1'b0;
    tick();
    n_run++; if ({cnt8, tc8, uf8} !== {8'hFF, 2'b11}) begin n_fail++; $display("FAIL wrap_down got=%h tc=%b uf=%b exp=ff 1 1", cnt8, tc8, uf8); end
  endtask

  task automatic test_sat();
    do_reset(1'b0);
    load = 1'b1; lv4 = 4'h1;
    tick();
    load = 1'b0; en = 1'b1; dir = 1'b0; sel = 2'b00; num = 1'b1;
    tick();
    n_run++; if ({cnt4, tc4, uf4} !== {4'h0, 2'b00}) begin n_fail++; $display("FAIL sat_dn1 got=%h tc=%b uf=%b exp=0 0 0", cnt4, tc4, uf4); end
    tick();
    n_run++; if ({cnt4, tc4, uf4} !== {4'h0, 2'b11}) begin n_fail++; $display("FAIL sat_dn2 got=%h tc=%b uf=%b exp=0 1 1", cnt4, tc4, uf4); end
    tick();
    n_run++; if ({cnt4, tc4, uf4} !== {4'h0, 2'b11}) begin n_fail++; $display("FAIL sat_dn3 got=%h tc=%b uf=%b exp=0 1 1", cnt4, tc4, uf4); end
    en = 1'b0;
    tick();
    n_run++; if ({tc4, uf4} !== 2'b01) begin n_fail++; $display("FAIL sat_tc_drop got tc=%b uf=%b exp=0 1", tc4, uf4); end
    load = 1'b1; lv4 = 4'hF;
    tick();
    load = 1'b0; en = 1'b1; dir = 1'b1;
    tick();
    n_run++; if ({cnt4, tc4, of4} !== {4'hF, 2'b11}) begin n_fail++; $display("FAIL sat_up got=%h tc=%b of=%b exp=f 1 1", cnt4, tc4, of4); end
  endtask

  task automatic test_priority();
    do_reset(1'b0);
    en = 1'b1; dir = 1'b1; sel = 2'b00; num = 1'b1; load = 1'b1; lv8 = 8'h55;
    tick();
    load = 1'b0; en = 1'b0;
    n_run++; if (cnt8 !== 8'h55) begin n_fail++; $display("FAIL load_vs_evt got=%h exp=55", cnt8); end
    sel = 2'b01; num = 1'b0;
    for (int i = 0; i < 8; i++) begin num = ~num; tick(); end
    n_run++; if (cnt8 !== 8'h55) begin n_fail++; $display("FAIL en_off got=%h exp=55", cnt8); end
    num = 1'b1;
    tick();
    en = 1'b1;
    tick();
    n_run++; if (cnt8 !== 8'h55) begin n_fail++; $display("FAIL reenable_mid_pulse got=%h exp=55", cnt8); end
    load = 1'b1; lv8 = 8'hFF; sel = 2'b00;
    tick();
    load = 1'b0;
    tick();
    load = 1'b1; lv8 = 8'h37;
    tick();
    load = 1'b0;
    n_run++; if ({cnt8, of8} !== {8'h37, 1'b1}) begin n_fail++; $display("FAIL pre_reset got=%h of=%b exp=37 1", cnt8, of8); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_run++; if ({cnt8, of8, uf8, tc8} !== {8'h00, 3'b000}) begin n_fail++; $display("FAIL mid_reset got=%h flags=%b exp=00 000", cnt8, {of8, uf8, tc8}); end
  endtask

  initial begin
    test_reset();
    test_level();
    test_edges();
    test_wrap();
    test_sat();
    test_priority();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/edge_counter_param.md
Name: edge_counter_param

Overview:
Parametrised event counter, successor to the 8-bit pulse counter. Counts qualified events on i_num_i, with these additions:
- selectable edge mode
- up/down direction
- synchronous load
- wrap or saturate at the limits
- sticky overflow/underflow flags with clear
- one-cycle terminal-count pulse
Sits beside control/stat logic as a generic event/statistics counter; i_num_i is already synchronous to i_clk.

Parameters:
WIDTH, 8, counter width in bits; legal range 2..32.
SAT, 0, limit mode: 0 = wrap at limits, 1 = saturate (hold) at limits.

Ports:
i_clk  input  1  single clock; all logic on posedge.
i_rst_n  input  1  reset; synchronous, active-low.
i_num_i  input  1  event input, synchronous to i_clk.
i_en  input  1  count enable; 0 = counting frozen.
i_dir  input  1  1 = count up, 0 = count down.
i_edge_sel  input  2  event qualifier: 00 level-high, 01 rising, 10 falling, 11 both edges.
i_load  input  1  synchronous load strobe.
i_load_val  input  WIDTH  value written on load.
i_of_clr  input  1  clears o_of and o_uf.
o_of  output  1  sticky overflow flag.
o_uf  output  1  sticky underflow flag.
o_tc  output  1  one-cycle terminal-count pulse.
c_cnt  output  WIDTH  current count.

Behaviour:
- Reset is sampled on posedge i_clk with i_rst_n=0. It sets:
  - c_cnt=0, o_of=0, o_uf=0, o_tc=0
  - num_q <= i_num_i, so the level present at reset release never produces a spurious edge.
- num_q is a registered copy of i_num_i. It updates every non-reset cycle, regardless of i_en and i_load.
- evt (combinational) by i_edge_sel:
  - 00: i_num_i
  - 01: i_num_i & ~num_q
  - 10: ~i_num_i & num_q
  - 11: i_num_i ^ num_q
- Latency: an event sampled at posedge N is reflected in c_cnt after posedge N. No further pipeline delay.
- Priority per cycle: reset > load > count.
- Load (i_load=1):
  - c_cnt <= i_load_val, regardless of i_en; any simultaneous evt is discarded.
  - No flag change; o_tc=0.
- Count step: taken when i_en=1, i_load=0, evt=1.
  - Up, c_cnt < MAX (MAX = 2^WIDTH-1): c_cnt+1.
  - Up, c_cnt == MAX:
    - SAT=0: c_cnt <= 0.
    - SAT=1: c_cnt holds MAX.
    - Either mode: o_of <= 1, o_tc=1 for that cycle.
  - Down, c_cnt > 0: c_cnt-1.
  - Down, c_cnt == 0:
    - SAT=0: c_cnt <= MAX.
    - SAT=1: c_cnt holds 0.
    - Either mode: o_uf <= 1, o_tc=1.
  - In saturate mode every further event at the limit re-sets the flag and re-pulses o_tc.
- i_en=0: c_cnt holds and events are lost. num_q still tracks, so re-enabling mid-pulse does not fabricate an edge.
- o_tc is registered: high for exactly the cycle after the limit-crossing step, otherwise 0.
- Flags:
  - o_of/o_uf stay set until i_of_clr=1 or reset.
  - If i_of_clr and a new limit event occur in the same cycle, set wins and the flag remains 1.
  - i_of_clr has no effect on c_cnt.
- Reset asserted mid-count overrides everything in that cycle.
- i_dir and i_edge_sel may change any cycle. The new value applies to the evt of that same cycle.
- Arithmetic is modulo 2^WIDTH, with no intermediate wider results exposed.

Test Plan:
1. Reset and level mode:
   - WIDTH=8, SAT=0, edge_sel=00, en=1, dir=1, i_num_i held 1 for 5 cycles after reset release.
   - Required: c_cnt = 1,2,3,4,5 after each edge; o_of=0.
2. Rising mode with a toggling input:
   - edge_sel=01, i_num_i toggling every cycle for 20 cycles.
   - Required: c_cnt=10.
   - Same stimulus with edge_sel=11: c_cnt=20.
   - With i_num_i=1 at reset release: no count on the first cycle.
3. Wrap up, then clear:
   - Load 8'hFE, then 3 up events.
   - Required: c_cnt = FF, 00, 01; o_tc high for one cycle after FF→00; o_of=1 and stays 1.
   - Then pulse i_of_clr: o_of=0.
   - Clear coincident with a wrap: o_of remains 1.
4. Saturate down:
   - WIDTH=4, SAT=1, load 4'h1, dir=0, 3 events.
   - Required: c_cnt = 0, 0, 0; o_uf=1; o_tc pulses on the 2nd and 3rd events.
5. Priority:
   - Event, i_load=1 and i_load_val=8'h55 in the same cycle: c_cnt=55, with no increment.
   - en=0 with 4 events: c_cnt unchanged.
   - Reset asserted mid-stream at c_cnt=8'h37: c_cnt=0 and flags=0 on that posedge.
